// File: rtl/switch_debounce_led_ctrl_if.sv
// -----------------------------------------------------------------------------
// switch_debounce_led_ctrl_if
//   Groups the pad-side signals of the switch debouncer / LED controller.
//   The environment that drives the switches and the mode uses the master
//   modport. The debouncer block itself uses the slave modport.
//
//   Signals (NUM_CH channels):
//     i_Switch   [NUM_CH]  raw asynchronous switch levels (1 = pressed)
//     i_Mode     [2]       LED mode: 00 direct, 01 inverted, 10 toggle, 11 = 00
//     o_LED      [NUM_CH]  LED drive (1 = lit)
//     o_Press    [NUM_CH]  one-cycle pulse on debounced 0->1
//     o_Release  [NUM_CH]  one-cycle pulse on debounced 1->0
// -----------------------------------------------------------------------------
interface switch_debounce_led_ctrl_if #(
  parameter int NUM_CH = 4
) ();

  logic [NUM_CH-1:0] i_Switch;
  logic [1:0]        i_Mode;
  logic [NUM_CH-1:0] o_LED;
  logic [NUM_CH-1:0] o_Press;
  logic [NUM_CH-1:0] o_Release;

  // Switch/mode source side (board model or test environment).
  modport master (
    output i_Switch,
    output i_Mode,
    input  o_LED,
    input  o_Press,
    input  o_Release
  );

  // Debouncer / LED controller side.
  modport slave (
    input  i_Switch,
    input  i_Mode,
    output o_LED,
    output o_Press,
    output o_Release
  );

endinterface : switch_debounce_led_ctrl_if

// File: rtl/switch_debounce_led_ctrl.sv
// -----------------------------------------------------------------------------
// switch_debounce_led_ctrl
//   Takes NUM_CH raw board switches and passes each one through a two-flop
//   synchroniser and a stability-counter debouncer. It drives one LED per
//   channel. The LED follows a runtime-selected mode: direct, inverted, or
//   toggle-on-release. It also reports one-cycle press/release pulses taken
//   from the debounced level. All channels are fully independent.
//
//   Parameters:
//     NUM_CH          number of switch/LED channels (1..16)
//     DEBOUNCE_LIMIT  consecutive differing synchronised samples needed to
//                     accept a new level (>= 2)
//
//   Ports:
//     i_Clk    system clock, all logic on the rising edge
//     i_Rst_L  synchronous active-low reset
//     bus      slave side of switch_debounce_led_ctrl_if
//              (i_Switch, i_Mode in; o_LED, o_Press, o_Release out)
//
//   Timing: a clean step on i_Switch reaches the debounced level
//   DEBOUNCE_LIMIT+2 edges later. The press/release pulses follow one edge
//   after that. o_LED is a pure mux of registers, so a mode change shows up
//   in the same cycle.
// -----------------------------------------------------------------------------
module switch_debounce_led_ctrl #(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_L,
  switch_debounce_led_ctrl_if.slave     bus
);

  // A limit of 2 would give a one-bit counter. Keep the width at least 1.
  localparam int CNT_W = ($clog2(DEBOUNCE_LIMIT) < 1) ? 1 : $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_INVERT = 2'b01;
  localparam logic [1:0] MODE_TOGGLE = 2'b10;
  localparam logic [1:0] MODE_ALIAS  = 2'b11;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] sync1_r;     // first metastability flop
  logic [NUM_CH-1:0] sync2_r;     // synchronised switch level
  logic [NUM_CH-1:0] stable_r;    // accepted (debounced) level
  logic [NUM_CH-1:0] stable_d_r;  // debounced level one edge later, for edge detect
  logic [NUM_CH-1:0] press_r;
  logic [NUM_CH-1:0] release_r;
  logic [NUM_CH-1:0] toggle_r;
  logic [CNT_W-1:0]  cnt_r [NUM_CH];

  logic [NUM_CH-1:0] mismatch_s;
  logic [NUM_CH-1:0] rise_s;
  logic [NUM_CH-1:0] fall_s;
  logic [NUM_CH-1:0] led_s;

  // ---------------------------------------------------------------------------
  // LED source selection. Code 11 is an alias of direct, so that an
  // unexpected mode value still gives a sensible display.
  // ---------------------------------------------------------------------------
  function automatic logic [NUM_CH-1:0] led_select(
    input logic [1:0]        mode,
    input logic [NUM_CH-1:0] stable,
    input logic [NUM_CH-1:0] toggle
  );
    logic [NUM_CH-1:0] sel;
    sel = stable;
    case (mode)
      MODE_DIRECT: sel = stable;
      MODE_INVERT: sel = ~stable;
      MODE_TOGGLE: sel = toggle;
      MODE_ALIAS:  sel = stable;
      default:     sel = stable;
    endcase
    return sel;
  endfunction

  // Two-flop synchroniser for the asynchronous pad levels.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync1_r <= {NUM_CH{1'b0}};
      sync2_r <= {NUM_CH{1'b0}};
    end else begin
      sync1_r <= bus.i_Switch;
      sync2_r <= sync1_r;
    end
  end

  // A channel is counting whenever its synchronised level disagrees with the
  // accepted level.
  always_comb begin
    mismatch_s = sync2_r ^ stable_r;
  end

  // Per-channel stability counter. A change is accepted on the
  // DEBOUNCE_LIMIT-th consecutive mismatching sample. A single agreeing
  // sample clears the count (glitch rejection). The count never goes past
  // CNT_MAX, so it cannot wrap.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      stable_r <= {NUM_CH{1'b0}};
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_r[ch] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (!mismatch_s[ch]) begin
          cnt_r[ch] <= {CNT_W{1'b0}};
        end else if (cnt_r[ch] == CNT_MAX) begin
          stable_r[ch] <= sync2_r[ch];
          cnt_r[ch]    <= {CNT_W{1'b0}};
        end else begin
          cnt_r[ch] <= cnt_r[ch] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Edges of the debounced level, seen one edge after the level moved.
  always_comb begin
    rise_s = stable_r & ~stable_d_r;
    fall_s = ~stable_r & stable_d_r;
  end

  // Registered press/release pulses and the toggle state. The toggle state
  // flips on the same edge that raises o_Release. It runs in every mode, so
  // that selecting toggle mode later shows a history that is consistent.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      stable_d_r <= {NUM_CH{1'b0}};
      press_r    <= {NUM_CH{1'b0}};
      release_r  <= {NUM_CH{1'b0}};
      toggle_r   <= {NUM_CH{1'b0}};
    end else begin
      stable_d_r <= stable_r;
      press_r    <= rise_s;
      release_r  <= fall_s;
      toggle_r   <= toggle_r ^ fall_s;
    end
  end

  // LED drive is a mux of registered state and has no added latency. Because
  // of this, a mode change takes effect in the same cycle.
  always_comb begin
    led_s = led_select(bus.i_Mode, stable_r, toggle_r);
  end

  assign bus.o_LED     = led_s;
  assign bus.o_Press   = press_r;
  assign bus.o_Release = release_r;

endmodule : switch_debounce_led_ctrl
